max_exp_batch_ctrl: RTL
=======================

MAX_EXP_BATCH_CTRL -- requirements
Module: max_exp_batch_ctrl

Interface
REQ-001 SHALL have parameter: FP16_exp_width, default 5, exponent field width; every exponent is FP16_exp_width+1 bits (E).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cfg_groups  input  4  groups per batch; 0 means 16.
REQ-005 SHALL have port: in_valid  input  1  group-valid.
REQ-006 SHALL have port: in_ready  output  1  group accepted when in_valid && in_ready.
REQ-007 SHALL have port: in_skip  input  9  per-operand skip; bit 8 = operand 1, bit 0 = operand 9.
REQ-008 SHALL have port: in_exp  input  9*E  packed exponents; operand 1 in MSB slice, operand 9 in LSB slice.
REQ-009 SHALL have port: out_valid  output  1  batch result valid.
REQ-010 SHALL have port: out_ready  input  1  result consumed when out_valid && out_ready.
REQ-011 SHALL have port: out_max_exp  output  E  batch maximum exponent.
REQ-012 SHALL have port: out_cnt  output  8  count of non-skipped operands in batch.
REQ-013 SHALL have port: busy  output  1  high in ACCUM or DONE.

Function
REQ-014 SHALL implement FSM IDLE, ACCUM, DONE.
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM, 0 in DONE.
REQ-016 SHALL treat a skipped operand as exponent 0; unsigned compare; group max = max of 9 masked operands.
REQ-017 SHALL, on acceptance in IDLE, latch cfg_groups into a batch-length register, load running max with group max, load count with popcount(~in_skip), set group counter to 1.
REQ-018 SHALL, on acceptance in ACCUM, update running max = max(running max, group max), add popcount(~in_skip) to count, increment group counter.
REQ-019 SHALL ignore cfg_groups changes after the first group of a batch is accepted.
REQ-020 SHALL enter DONE on the edge accepting the last group (counter reaching batch length); batch length 1 goes IDLE->DONE directly.
REQ-021 SHALL assert out_valid exactly in DONE, first cycle after last-group acceptance (latency 1).
REQ-022 SHALL hold out_max_exp and out_cnt stable while out_valid && !out_ready.
REQ-023 SHALL return to IDLE on output handshake; in_ready rises the following cycle (no same-cycle bypass).
REQ-024 SHALL hold all state when in_valid=0 in IDLE/ACCUM (bubbles allowed mid-batch).
REQ-025 SHALL produce out_max_exp=0, out_cnt=0 for an all-skipped batch, out_valid still asserted.
REQ-026 SHALL keep out_cnt exact up to 144 (16 groups x 9), no saturation needed.

Reset
REQ-027 SHALL on rst_n=0 immediately force IDLE, in_ready=1 after release, out_valid=0, busy=0, out_max_exp=0, out_cnt=0, counters 0.
REQ-028 SHALL discard any partial batch or pending result when reset asserts mid-operation.

Configuration
REQ-029 SHALL honor macro MAX_EXP_SKIP_CNT_EN: defined -> count logic of REQ-017/018 present and out_cnt valid.
REQ-030 SHALL, without MAX_EXP_SKIP_CNT_EN, tie out_cnt to 0 and omit popcount/count registers; all other behaviour identical.

Verification
REQ-031 SHALL test: cfg_groups=3, groups max 5,17,9, skip=0 -> out_max_exp=17, out_cnt=27, out_valid one cycle after third acceptance.
REQ-032 SHALL test: cfg_groups=1, in_exp operand 1=31 with in_skip=9'h100, others 4 -> out_max_exp=4, out_cnt=8.
REQ-033 SHALL test: cfg_groups=2, all in_skip=9'h1FF -> out_max_exp=0, out_cnt=0, out_valid=1.
REQ-034 SHALL test: out_ready=0 for 5 cycles in DONE -> in_ready=0, outputs stable; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 SHALL test: cfg_groups=0, 16 groups with in_valid bubbles, operand 9 of group 16 = 63 -> out_max_exp=63, out_cnt=144.
REQ-036 SHALL test: rst_n low after 2 of 4 groups -> out_valid=0, IDLE; new 1-group batch (cfg_groups=1) then completes correctly.

Source files
------------

// File: rtl/max_exp_batch_ctrl.sv
// Batch maximum-exponent controller: folds groups of 9 masked exponents into a running max.
// Optional operand counting is enabled by defining MAX_EXP_SKIP_CNT_EN.
module max_exp_batch_ctrl #(
    parameter int FP16_exp_width = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [3:0]                        cfg_groups,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [8:0]                        in_skip,
    input  logic [9*(FP16_exp_width+1)-1:0]   in_exp,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [FP16_exp_width:0]           out_max_exp,
    output logic [7:0]                        out_cnt,
    output logic                              busy
);

    localparam int E = FP16_exp_width + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t         state_q;
    logic [4:0]     len_q;
    logic [4:0]     gcnt_q;
    logic [E-1:0]   max_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;

    logic [E-1:0]   grp_max_d;
    logic [4:0]     len_d;
    logic [4:0]     gcnt_d;
    logic           acc;

    function automatic logic [E-1:0] max_u(input logic [E-1:0] a, input logic [E-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Skipped operands contribute exponent 0, so they can never win the compare.
    always_comb begin
        grp_max_d = '0;
        for (int i = 0; i < 9; i++) begin
            if (!in_skip[i]) begin
                grp_max_d = max_u(grp_max_d, in_exp[i*E +: E]);
            end
        end
    end

    assign len_d  = (cfg_groups == 4'd0) ? 5'd16 : {1'b0, cfg_groups};
    assign gcnt_d = gcnt_q + 5'd1;
    assign acc    = in_valid && in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            gcnt_q      <= '0;
            max_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc) begin
                        len_q  <= len_d;
                        max_q  <= grp_max_d;
                        gcnt_q <= 5'd1;
                        busy_q <= 1'b1;
                        if (len_d == 5'd1) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (acc) begin
                        max_q  <= max_u(max_q, grp_max_d);
                        gcnt_q <= gcnt_d;
                        if (gcnt_d == len_q) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // in_ready only returns on the cycle after the handshake.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        gcnt_q      <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef MAX_EXP_SKIP_CNT_EN
    logic [7:0] cnt_q;
    logic [3:0] grp_pop_d;

    function automatic logic [3:0] popcnt9(input logic [8:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    assign grp_pop_d = popcnt9(~in_skip);

    // Maximum is 16 x 9 = 144, which fits 8 bits without saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (acc) begin
            cnt_q <= (state_q == IDLE) ? {4'b0000, grp_pop_d} : cnt_q + {4'b0000, grp_pop_d};
        end
    end

    assign out_cnt = cnt_q;
`else
    assign out_cnt = '0;
`endif

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_max_exp = max_q;
    assign busy        = busy_q;

endmodule
